fp_pow2_scale_seq: RTL and testbench

Multi-cycle sequencer that divides an IEEE-754 single-precision operand by 2^n using one shared halving stage. The stage has the same semantics as the combinational halving unit: exponent minus one, zero-flush, inf/NaN passthrough. The block applies the stage once per cycle under a counter and exits early on terminal values. It sits between the Nios II custom-instruction port and the CORDIC core and performs argument pre-scaling (x/2, x/128, …) without a separate combinational unit per scale factor.

---
 rtl/fp_pow2_scale_seq_if.sv | 22 ++
 rtl/fp_pow2_scale_seq.sv | 81 ++++++++
 tb/tb_fp_pow2_scale_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_pow2_scale_seq_if.sv
// rtl/fp_pow2_scale_seq_if.sv - request/result bundle for the pow2 scaling sequencer
interface fp_pow2_scale_seq_if #(
  parameter int CNT_W = 8
);
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;
  logic        busy;

  modport master (
    output clk_en, start, dataa, datab,
    input  result, done, busy
  );

  modport slave (
    input  clk_en, start, dataa, datab,
    output result, done, busy
  );
endinterface

// File: rtl/fp_pow2_scale_seq.sv
// rtl/fp_pow2_scale_seq.sv - divides an IEEE-754 single by 2^n with one shared halving stage
module fp_pow2_scale_seq #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  fp_pow2_scale_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       val_q, val_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;
  logic              done_q, done_d;
  logic              terminal;

  // Exponent 1 halves into the denormal range, so it is flushed to signed zero instead.
  function automatic logic [31:0] half(input logic [31:0] v);
    if (v[30:23] == 8'd1)
      half = {v[31], 31'b0};
    else
      half = {v[31], v[30:23] - 8'd1, v[22:0]};
  endfunction

  assign terminal = (val_q[30:23] == 8'h00) || (val_q[30:23] == 8'hFF);

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          val_d   = bus.dataa;
          cnt_d   = bus.datab[CNT_W-1:0];
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0 || terminal) begin
          result_d = val_q;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          val_d = half(val_q);
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      val_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (bus.clk_en) begin
      state_q  <= state_d;
      val_q    <= val_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fp_pow2_scale_seq.sv
// tb/tb_fp_pow2_scale_seq.sv - randomized self-checking bench for fp_pow2_scale_seq
module tb_fp_pow2_scale_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fp_pow2_scale_seq_if #(.CNT_W(8)) bus ();

  fp_pow2_scale_seq #(.CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Scaling by 2^-n is an exponent subtraction; once the exponent would reach 0 the value flushes.
  function automatic void model(input logic [31:0] x, input int n,
                                output logic [31:0] y, output int h);
    int e;
    e = int'(x[30:23]);
    if (e == 0 || e == 255) begin
      y = x; h = 0;
    end else if (n < e) begin
      y = x - (32'(n) << 23); h = n;
    end else begin
      y = {x[31], 31'b0}; h = e;
    end
  endfunction

  task automatic run_op(input logic [31:0] x, input int n,
                        output logic [31:0] res, output int lat, output int width);
    @(negedge clk);
    bus.dataa = x;
    bus.datab = ($urandom & 32'hFFFF_FF00) | 32'(n & 8'hFF);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) lat = -1;
    res = bus.result;
    width = 0;
    while (bus.done && width < 10) begin
      width++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r; int lat, w;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=%h", bus.result, 32'h0); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    bus.dataa = 32'h41A0_0000; bus.datab = 32'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b exp=1", bus.busy); end
    lat = 1;
    while (!bus.done && lat < 50) begin @(negedge clk); lat++; end
    r = bus.result;
    w = 0;
    while (bus.done && w < 10) begin w++; @(negedge clk); end
    checks++; if (r !== 32'h4120_0000) begin failures++; $display("FAIL first_result got=%h exp=%h", r, 32'h4120_0000); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL first_latency got=%0d exp=3", lat); end
    checks++; if (w !== 1) begin failures++; $display("FAIL first_done_width got=%0d exp=1", w); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_after_done got=%b exp=0", bus.busy); end
  endtask

  task automatic test_table();
    logic [31:0] xs [9] = '{32'h41A0_0000, 32'h42A0_0000, 32'h4370_0000, 32'h0000_0000,
                            32'h7F80_0000, 32'hC1A0_0000, 32'h0080_0000, 32'h8080_0000, 32'h0000_0001};
    int          ns [9] = '{7, 7, 7, 5, 10, 1, 3, 3, 4};
    logic [31:0] ys [9] = '{32'h3E20_0000, 32'h3F20_0000, 32'h3FF0_0000, 32'h0000_0000,
                            32'h7F80_0000, 32'hC120_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001};
    int          ls [9] = '{9, 9, 9, 2, 2, 3, 3, 3, 2};
    logic [31:0] r; int lat, w;
    for (int i = 0; i < 9; i++) begin
      run_op(xs[i], ns[i], r, lat, w);
      checks++; if (r !== ys[i]) begin failures++; $display("FAIL table_result[%0d] got=%h exp=%h", i, r, ys[i]); end
      checks++; if (lat !== ls[i]) begin failures++; $display("FAIL table_latency[%0d] got=%0d exp=%0d", i, lat, ls[i]); end
      checks++; if (w !== 1) begin failures++; $display("FAIL table_done_width[%0d] got=%0d exp=1", i, w); end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, r; int n, h, lat, w, e;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: e = 0;
        1: e = 255;
        2: e = $urandom_range(1, 3);
        default: e = $urandom_range(1, 254);
      endcase
      x = {1'($urandom), 8'(e), 23'($urandom)};
      n = (i % 3 == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      model(x, n, y, h);
      run_op(x, n, r, lat, w);
      checks++; if (r !== y) begin failures++; $display("FAIL rand_result x=%h n=%0d got=%h exp=%h", x, n, r, y); end
      checks++; if (lat !== h + 2) begin failures++; $display("FAIL rand_latency x=%h n=%0d got=%0d exp=%0d", x, n, lat, h + 2); end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    bus.dataa = 32'h41A0_0000; bus.datab = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; lat = 1;
    while (!bus.done && lat < 50) begin
      if (lat == 3) begin bus.dataa = 32'h4370_0000; bus.datab = 32'd1; bus.start = 1'b1; end
      if (lat == 4) bus.start = 1'b0;
      @(negedge clk); lat++;
    end
    checks++; if (bus.result !== 32'h3E20_0000) begin failures++; $display("FAIL ignored_start_result got=%h exp=%h", bus.result, 32'h3E20_0000); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL ignored_start_latency got=%0d exp=9", lat); end
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignored_start_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_clk_en();
    int lat;
    @(negedge clk);
    bus.dataa = 32'h41A0_0000; bus.datab = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; lat = 1;
    while (!bus.done && lat < 50) begin
      if (lat == 3) bus.clk_en = 1'b0;
      if (lat == 7) bus.clk_en = 1'b1;
      @(negedge clk); lat++;
    end
    checks++; if (lat !== 13) begin failures++; $display("FAIL clk_en_latency got=%0d exp=13", lat); end
    checks++; if (bus.result !== 32'h3E20_0000) begin failures++; $display("FAIL clk_en_result got=%h exp=%h", bus.result, 32'h3E20_0000); end
    // Freezing while done is high must stretch the pulse.
    bus.clk_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL done_stretch got=%b exp=1", bus.done); end
    bus.clk_en = 1'b1;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL done_release got=%b exp=0", bus.done); end
  endtask

  task automatic test_back_to_back();
    int t, first, second; logic prev;
    @(negedge clk);
    bus.dataa = 32'h41A0_0000; bus.datab = 32'd2; bus.start = 1'b1;
    first = -1; second = -1; prev = 1'b0;
    for (t = 0; t < 60 && second < 0; t++) begin
      @(negedge clk);
      if (bus.done && !prev) begin
        if (first < 0) first = t; else second = t;
      end
      prev = bus.done;
    end
    bus.start = 1'b0;
    checks++; if (second - first !== 5 || first < 0) begin failures++; $display("FAIL back_to_back_period got=%0d exp=5", second - first); end
    checks++; if (bus.result !== 32'h40A0_0000) begin failures++; $display("FAIL back_to_back_result got=%h exp=%h", bus.result, 32'h40A0_0000); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [31:0] r; int lat, w; bit seen;
    @(negedge clk);
    bus.dataa = 32'h41A0_0000; bus.datab = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL async_reset_result got=%h exp=%h", bus.result, 32'h0); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL async_reset_flags got=%b%b exp=00", bus.busy, bus.done); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (bus.done) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL async_reset_no_done got=%b exp=0", seen); end
    run_op(32'h41A0_0000, 7, r, lat, w);
    checks++; if (r !== 32'h3E20_0000 || lat !== 9) begin failures++; $display("FAIL post_reset_op got=%h/%0d exp=%h/9", r, lat, 32'h3E20_0000); end
  endtask

  initial begin
    bus.clk_en = 1'b1; bus.start = 1'b0; bus.dataa = '0; bus.datab = '0;
    test_reset();
    test_table();
    test_random();
    test_start_ignored();
    test_clk_en();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
